bit_capture_arbiter: RTL
========================

BIT_CAPTURE_ARBITER -- requirements
Module: bit_capture_arbiter

Interface
REQ-001 SHALL have parameter WORD_W, default 32, capture word width in bits.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, idle-cycle abort limit; used only with CAPTURE_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports tst_req / usb_req  input  1 each  request for the shared capture register.
REQ-006 SHALL have ports tst_valid / usb_valid  input  1 each  one-cycle bit strobe, synchronous to clk.
REQ-007 SHALL have ports tst_data / usb_data  input  1 each  serial bit, sampled when the matching valid is high.
REQ-008 SHALL have ports tst_gnt / usb_gnt  output  1 each  grant; at most one high at any time.
REQ-009 SHALL have port word_out  output  WORD_W  assembled word.
REQ-010 SHALL have port word_src  output  1  source of word_out: 0 = test, 1 = usb.
REQ-011 SHALL have port word_valid  output  1  word_out is complete and held.
REQ-012 SHALL have port word_ready  input  1  consumer accepts word_out.
REQ-013 SHALL have port bit_count  output  clog2(WORD_W)  index of the next bit to be written.
REQ-014 SHALL have port abort  output  1  one-cycle pulse on timeout abort.

Function
REQ-015 SHALL implement an FSM with states IDLE, CAPTURE and HOLD; all outputs registered.
REQ-016 In IDLE, SHALL sample tst_req/usb_req each cycle; with a single request, that source is granted.
REQ-017 With both requests in IDLE, SHALL grant the source not served last (round-robin pointer last_src).
REQ-018 On grant, SHALL enter CAPTURE, raise the matching gnt on the same edge, clear word_out to 0, set bit_count to 0 and set word_src.
REQ-019 In CAPTURE, on a granted-source valid, SHALL write word_out[bit_count] = data (LSB first) and increment bit_count.
REQ-020 SHALL ignore valid strobes from the non-granted source; their bits are dropped without side effects.
REQ-021 SHALL sample requests only in IDLE; deasserting req during CAPTURE does not end the capture.
REQ-022 On the edge that writes bit WORD_W-1, SHALL enter HOLD, drop gnt, assert word_valid and wrap bit_count to 0.
REQ-023 In HOLD, SHALL keep word_out and word_src stable until word_valid and word_ready are both high on an edge.
REQ-024 On that handshake edge, SHALL deassert word_valid, set last_src to word_src and return to IDLE.
REQ-025 SHALL spend at least one cycle in IDLE between packets; grant latency is one clock from a sampled req.
REQ-026 SHALL ignore word_ready outside HOLD.

Reset
REQ-027 Asserting reset_n low SHALL immediately force IDLE, with gnts, word_valid and abort at 0, word_out at 0, bit_count at 0, word_src at 0 and last_src at 1 (usb), so test wins the first tie.
REQ-028 Reset during CAPTURE or HOLD SHALL discard the partial or pending word; no handshake completes.
REQ-029 SHALL leave reset on the first rising clk edge after reset_n goes high, with no stored state from before reset.

Configuration
REQ-030 With macro CAPTURE_TIMEOUT_EN defined, SHALL count consecutive CAPTURE cycles without a granted valid, resetting the count on each such valid.
REQ-031 When the count reaches TIMEOUT_CYC, SHALL pulse abort for one cycle, drop gnt, discard the word, set last_src to the aborted source and return to IDLE.
REQ-032 Without CAPTURE_TIMEOUT_EN, SHALL have no timeout counter, tie abort to 0 and wait in CAPTURE indefinitely.

Verification
REQ-033 Only tst_req, then 32 tst_valid with bit i = i[0] -> tst_gnt one clk later, word_out = 0xAAAAAAAA, word_src = 0, word_valid after the 32nd bit.
REQ-034 Both requests in IDLE after reset -> tst_gnt first; after handshake, both requesting again -> usb_gnt; alternation continues.
REQ-035 During a test capture, interleaved usb_valid with usb_data = 1 and tst_data = 0 -> word_out = 0x00000000 and usb strobes are dropped.
REQ-036 word_ready held low for 10 cycles in HOLD -> word_out stable and no new gnt; word_ready high -> IDLE next cycle.
REQ-037 reset_n low after 7 captured bits -> outputs at 0 immediately; a new capture after release starts at bit_count 0.
REQ-038 With CAPTURE_TIMEOUT_EN and TIMEOUT_CYC = 16, 5 bits then no valid -> abort after 16 idle cycles, gnt low, no word_valid.

Source files
------------

// File: rtl/bit_capture_arbiter.sv
// Two-source serial bit capture into one shared word register, round-robin arbitrated.
// Latency: grant one clk after a sampled req; word_valid on the edge that writes the last bit.
// Backpressure: the word is held until word_ready; optional abort via macro CAPTURE_TIMEOUT_EN.
module bit_capture_arbiter #(
  parameter int WORD_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 tst_req,
  input  logic                                 usb_req,
  input  logic                                 tst_valid,
  input  logic                                 usb_valid,
  input  logic                                 tst_data,
  input  logic                                 usb_data,
  output logic                                 tst_gnt,
  output logic                                 usb_gnt,
  output logic [WORD_W-1:0]                    word_out,
  output logic                                 word_src,
  output logic                                 word_valid,
  input  logic                                 word_ready,
  output logic [((WORD_W>1)?$clog2(WORD_W):1)-1:0] bit_count,
  output logic                                 abort
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

  state_t             state_q, state_d;
  logic               last_src;
  logic               any_req, sel_src;
  logic               g_valid, g_data, last_bit, timeout_hit;

  logic               tst_gnt_d, usb_gnt_d, word_src_d, word_valid_d, last_src_d, abort_d;
  logic [WORD_W-1:0]  word_d;
  logic [CNT_W-1:0]   cnt_d;

  assign any_req  = tst_req | usb_req;
  // On a tie the source not served last wins.
  assign sel_src  = (tst_req && usb_req) ? ~last_src : usb_req;
  assign g_valid  = (state_q == CAPTURE) && (word_src ? usb_valid : tst_valid);
  assign g_data   = word_src ? usb_data : tst_data;
  assign last_bit = g_valid && (bit_count == CNT_W'(WORD_W - 1));

`ifdef CAPTURE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  logic [TO_W-1:0] idle_cnt;
  logic            abort_q;

  assign timeout_hit = (state_q == CAPTURE) && !g_valid &&
                       (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
      abort_q  <= 1'b0;
    end else begin
      abort_q <= abort_d;
      if (state_q != CAPTURE || g_valid || timeout_hit) idle_cnt <= '0;
      else                                             idle_cnt <= idle_cnt + TO_W'(1);
    end
  end

  assign abort = abort_q;
`else
  assign timeout_hit = 1'b0;
  assign abort       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = CAPTURE;
      CAPTURE: begin
        if (timeout_hit)   state_d = IDLE;
        else if (last_bit) state_d = HOLD;
      end
      HOLD:    if (word_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tst_gnt_d    = tst_gnt;
    usb_gnt_d    = usb_gnt;
    word_d       = word_out;
    cnt_d        = bit_count;
    word_src_d   = word_src;
    word_valid_d = word_valid;
    last_src_d   = last_src;
    abort_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          tst_gnt_d  = ~sel_src;
          usb_gnt_d  = sel_src;
          word_d     = '0;
          cnt_d      = '0;
          word_src_d = sel_src;
        end
      end
      CAPTURE: begin
        if (timeout_hit) begin
          tst_gnt_d  = 1'b0;
          usb_gnt_d  = 1'b0;
          word_d     = '0;
          cnt_d      = '0;
          abort_d    = 1'b1;
          last_src_d = word_src;
        end else if (g_valid) begin
          word_d[bit_count] = g_data;
          if (last_bit) begin
            cnt_d        = '0;
            tst_gnt_d    = 1'b0;
            usb_gnt_d    = 1'b0;
            word_valid_d = 1'b1;
          end else begin
            cnt_d = bit_count + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (word_ready) begin
          word_valid_d = 1'b0;
          last_src_d   = word_src;
        end
      end
      default: begin
        tst_gnt_d    = 1'b0;
        usb_gnt_d    = 1'b0;
        word_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tst_gnt    <= 1'b0;
      usb_gnt    <= 1'b0;
      word_out   <= '0;
      bit_count  <= '0;
      word_src   <= 1'b0;
      word_valid <= 1'b0;
      last_src   <= 1'b1;
    end else begin
      tst_gnt    <= tst_gnt_d;
      usb_gnt    <= usb_gnt_d;
      word_out   <= word_d;
      bit_count  <= cnt_d;
      word_src   <= word_src_d;
      word_valid <= word_valid_d;
      last_src   <= last_src_d;
    end
  end

endmodule
